// File: rtl/rf_pkg.sv
// Shared constants and types for the 2-read/1-write register file.
package rf_pkg;

  localparam int unsigned RF_ADDR_W   = 5;
  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_NUM_REGS = 32;
  localparam int unsigned RF_ZERO_IDX = 0;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

endpackage : rf_pkg

// File: rtl/rf_clear_seq.sv
// Soft-clear sequencer: walks indices 1..NUM_REGS-1, one per cycle, after a clr_req pulse.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr_req,
  output logic              o_clr_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_idx
);

  localparam int unsigned      NUM_REGS  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  rf_state_t         r_state;
  rf_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic              r_busy;
  logic              w_busy_nxt;

  // State, index and busy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RF_IDLE;
      r_idx   <= FIRST_IDX;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Terminal compare precedes the increment so the index never wraps to 0
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_busy_nxt  = r_busy;
    case (r_state)
      RF_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = RF_CLEAR;
          w_idx_nxt   = FIRST_IDX;
          w_busy_nxt  = 1'b1;
        end
      end
      RF_CLEAR: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = RF_IDLE;
          w_idx_nxt   = FIRST_IDX;
          w_busy_nxt  = 1'b0;
        end else begin
          w_idx_nxt   = r_idx + ADDR_W'(1);
        end
      end
      default: begin
        w_state_nxt = RF_IDLE;
        w_idx_nxt   = FIRST_IDX;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign o_clr_busy = r_busy;
  assign o_clr_we   = r_busy;
  assign o_clr_idx  = r_idx;

endmodule : rf_clear_seq

// File: rtl/register_file_2r1w.sv
// 32x32 general register file: two combinational read ports, one write port,
// hardwired r0, optional write-to-read bypass, sequenced soft clear and debug read.
module register_file_2r1w
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned       NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(RF_ZERO_IDX);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic              w_clr_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              w_wr_fire;

  rf_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr_req  (clr_req),
    .o_clr_busy (w_clr_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_idx  (w_clr_idx)
  );

  // A normal write only lands outside the clear sequence and never on r0
  assign w_wr_fire = wr_en && (wr_addr != ZERO_IDX) && !w_clr_busy;

  // Storage; the clear engine has priority over normal writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr_fire) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Read ports: r0 forced to zero, then optional bypass of the in-flight write
  always_comb begin
    rd_data_a = r_mem[rd_addr_a];
    if (rd_addr_a == ZERO_IDX) begin
      rd_data_a = '0;
    end else if (BYPASS && w_wr_fire && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end
  end

  always_comb begin
    rd_data_b = r_mem[rd_addr_b];
    if (rd_addr_b == ZERO_IDX) begin
      rd_data_b = '0;
    end else if (BYPASS && w_wr_fire && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end
  end

  assign dbg_data = (dbg_addr == ZERO_IDX) ? '0 : r_mem[dbg_addr];
  assign clr_busy = w_clr_busy;

endmodule : register_file_2r1w

// File: tb/tb_register_file_2r1w.sv
// Directed self-checking bench; a bypass and a no-bypass instance share all inputs.
module tb_register_file_2r1w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        clr_req;
  logic [4:0]  dbg_addr;

  logic [31:0] rd_data_a, rd_data_b, dbg_data;
  logic        clr_busy;
  logic [31:0] nb_rd_data_a, nb_rd_data_b, nb_dbg_data;
  logic        nb_clr_busy;

  int n_checks = 0;
  int n_errors = 0;
  int cnt;

  always #5 clk = ~clk;

  register_file_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .clr_req(clr_req), .clr_busy(clr_busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  register_file_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(nb_rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(nb_rd_data_b),
    .clr_req(clr_req), .clr_busy(nb_clr_busy), .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk(tag, dbg_data, 32'h0);
    end
  endtask

  // Count busy cycles after the clr_req edge, bounded
  task automatic count_busy(output int n);
    n = 0;
    while ((clr_busy === 1'b1) && (n < 100)) begin
      n++;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; clr_req = 1'b0; dbg_addr = '0;
    #1;
    chk("por_busy", 32'(clr_busy), 32'h0);
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();

    // 1. Asynchronous reset mid-cycle
    wr(5'd5, 32'h1357_9BDF);
    rd_addr_a = 5'd5; rd_addr_b = 5'd5;
    #1;
    chk("pre_rst_rd_a", rd_data_a, 32'h1357_9BDF);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rd_a", rd_data_a, 32'h0);
    chk("rst_rd_b", rd_data_b, 32'h0);
    chk("rst_busy", 32'(clr_busy), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    sweep_zero("rst_dbg");

    // 2. Write/read and r0
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; rd_addr_a = 5'd5;
    #1;
    chk("wr5_same_cyc_nb", nb_rd_data_a, 32'h0);
    tick();
    wr_en = 1'b0;
    #1;
    chk("wr5_rd_a", rd_data_a, 32'hDEAD_BEEF);
    chk("wr5_rd_a_nb", nb_rd_data_a, 32'hDEAD_BEEF);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234; rd_addr_a = 5'd0;
    #1;
    chk("r0_bypass", rd_data_a, 32'h0);
    tick();
    wr_en = 1'b0; dbg_addr = 5'd0;
    #1;
    chk("r0_rd_a", rd_data_a, 32'h0);
    chk("r0_dbg", dbg_data, 32'h0);

    // 3. Bypass vs stored value, independent ports
    wr(5'd7, 32'h0BAD_F00D);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
    rd_addr_b = 5'd7; rd_addr_a = 5'd5; dbg_addr = 5'd7;
    #1;
    chk("byp_rd_b", rd_data_b, 32'hA5A5_A5A5);
    chk("nobyp_rd_b", nb_rd_data_b, 32'h0BAD_F00D);
    chk("byp_rd_a_other", rd_data_a, 32'hDEAD_BEEF);
    chk("byp_dbg_old", dbg_data, 32'h0BAD_F00D);
    tick();
    wr_en = 1'b0;
    #1;
    chk("r7_after_b", rd_data_b, 32'hA5A5_A5A5);
    chk("r7_after_b_nb", nb_rd_data_b, 32'hA5A5_A5A5);

    // 4. Clear sequence over a filled file
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h1111_1111);
    rd_addr_a = 5'd3; rd_addr_b = 5'd10; dbg_addr = 5'd31;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    while ((clr_busy === 1'b1) && (cnt < 100)) begin
      cnt++;
      if (cnt == 5) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF_0003;
        #1;
        chk("clr_rd_a_r3_nobyp", rd_data_a, 32'h0);
        chk("clr_rd_b_r10_old", rd_data_b, 32'hAAAA_AAAA);
      end
      if (cnt == 11) chk("clr_rd_b_r10_zero", rd_data_b, 32'h0);
      if (cnt == 31) chk("clr_r31_old", dbg_data, 32'h1111_110F);
      tick();
      wr_en = 1'b0;
    end
    chk("clr_cycles", 32'(cnt), 32'd31);
    chk("clr_busy_low", 32'(clr_busy), 32'h0);
    chk("clr_r31_zero", dbg_data, 32'h0);
    chk("clr_r3_dropped", rd_data_a, 32'h0);
    sweep_zero("clr_dbg");

    // 5. Reset in clear cycle 10, then a full restart
    wr(5'd1, 32'h0000_0001);
    wr(5'd30, 32'h0000_0030);
    wr(5'd31, 32'h0000_0031);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    chk("c10_busy", 32'(clr_busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(clr_busy), 32'h0);
    chk("mid_rst_busy_nb", 32'(nb_clr_busy), 32'h0);
    dbg_addr = 5'd30;
    #1;
    chk("mid_rst_r30", dbg_data, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    wr(5'd30, 32'h0000_0130);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    count_busy(cnt);
    chk("restart_cycles", 32'(cnt), 32'd31);
    chk("restart_r30", dbg_data, 32'h0);

    // 6. clr_req with a same-cycle write, plus a second clr_req mid-clear
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h0000_0055; clr_req = 1'b1;
    dbg_addr = 5'd31;
    tick();
    wr_en = 1'b0; clr_req = 1'b0;
    cnt = 0;
    while ((clr_busy === 1'b1) && (cnt < 100)) begin
      cnt++;
      if (cnt == 1) chk("edge_r31_written", dbg_data, 32'h0000_0055);
      if (cnt == 10) clr_req = 1'b1;
      if (cnt == 31) chk("edge_r31_last", dbg_data, 32'h0000_0055);
      tick();
      clr_req = 1'b0;
    end
    chk("edge_cycles", 32'(cnt), 32'd31);
    chk("edge_r31_zero", dbg_data, 32'h0);
    tick();
    chk("edge_no_restart", 32'(clr_busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_register_file_2r1w
